// File: rtl/llr_extrinsic_sub_pkg.sv
// Shared constants and state encoding for the extrinsic-LLR extractor.
// LLR words are sign-magnitude: MSB = sign (1 = negative), remaining bits = magnitude.
package llr_extrinsic_sub_pkg;

    localparam int LLR_SIZE = 20;

    // Largest representable magnitude; saturating adds clamp to this value.
    localparam logic [LLR_SIZE-2:0] LLR_MAG_MAX = '1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_e;

endpackage

// File: rtl/llr_extrinsic_sub_sm_sat_add.sv
// Combinational saturating sign-magnitude adder. When the magnitudes are equal
// and the signs differ, the zero result takes y's sign; no -0 normalisation.
module sm_sat_add
    import llr_extrinsic_sub_pkg::*;
#(
    parameter int SIZE = LLR_SIZE
) (
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    output logic [SIZE-1:0] z
);

    localparam int MW = SIZE - 1;
    localparam logic [MW-1:0] MAG_MAX = '1;

    logic          x_s;
    logic          y_s;
    logic [MW-1:0] x_m;
    logic [MW-1:0] y_m;
    logic [SIZE-1:0] sum;

    assign x_s = x[SIZE-1];
    assign y_s = y[SIZE-1];
    assign x_m = x[MW-1:0];
    assign y_m = y[MW-1:0];

    // One spare bit catches the carry out of the magnitude field.
    assign sum = {1'b0, x_m} + {1'b0, y_m};

    always_comb begin
        z = '0;
        if (x_s == y_s) begin
            z = {x_s, (sum[SIZE-1] ? MAG_MAX : sum[MW-1:0])};
        end else if (x_m > y_m) begin
            z = {x_s, x_m - y_m};
        end else begin
            z = {y_s, y_m - x_m};
        end
    end

endmodule

// File: rtl/llr_extrinsic_sub.sv
// Streaming extrinsic-LLR extractor: accumulates a group of DEPTH LLRs, then
// emits total - in[i] for every element of the group in index order.
module llr_extrinsic_sub
    import llr_extrinsic_sub_pkg::*;
#(
    parameter int SIZE   = LLR_SIZE,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   out_data,
    output logic [ADDR_W-1:0] out_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_reg;
    state_e            state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;
    logic [SIZE-1:0]   acc_reg;
    logic [SIZE-1:0]   acc_next;
    logic              wr_en;

    logic [SIZE-1:0]   buf_mem [DEPTH];
    logic [SIZE-1:0]   buf_rd;
    logic [SIZE-1:0]   buf_neg;
    logic [SIZE-1:0]   acc_sum;
    logic [SIZE-1:0]   ext_sum;

    assign buf_rd  = buf_mem[cnt_reg];
    assign buf_neg = {~buf_rd[SIZE-1], buf_rd[SIZE-2:0]};

    sm_sat_add #(.SIZE(SIZE)) u_acc_add (
        .x (acc_reg),
        .y (in_data),
        .z (acc_sum)
    );

    // Subtraction is an add with the subtrahend's sign flipped.
    sm_sat_add #(.SIZE(SIZE)) u_ext_sub (
        .x (acc_reg),
        .y (buf_neg),
        .z (ext_sum)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_idx    = '0;

        case (state_reg)
            ST_ACCUM: begin
                in_ready = !flush;
                if (in_valid && !flush) begin
                    wr_en    = 1'b1;
                    acc_next = acc_sum;
                    if (cnt_reg == LAST_IDX) begin
                        cnt_next   = '0;
                        state_next = ST_EMIT;
                    end else begin
                        cnt_next = cnt_reg + ADDR_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_idx   = cnt_reg;
                out_data  = ext_sum;
                if (out_ready) begin
                    if (cnt_reg == LAST_IDX) begin
                        cnt_next   = '0;
                        acc_next   = '0;
                        state_next = ST_ACCUM;
                    end else begin
                        cnt_next = cnt_reg + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_ACCUM;
                cnt_next   = '0;
                acc_next   = '0;
            end
        endcase

        // Abort overrides everything; an output handshake this cycle is still delivered.
        if (flush) begin
            state_next = ST_ACCUM;
            cnt_next   = '0;
            acc_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACCUM;
            cnt_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
        end
    end

    // Group buffer needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[cnt_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_llr_extrinsic_sub.sv
// Self-checking bench for llr_extrinsic_sub (DEPTH = 4): integer-domain model
// plus directed vectors with hand-computed expected values.
module tb_llr_extrinsic_sub;

    localparam int SIZE   = 20;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int MAXM   = 524287;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SIZE-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SIZE-1:0]   out_data;
    logic [ADDR_W-1:0] out_idx;

    int checks = 0;
    int errors = 0;

    llr_extrinsic_sub #(.SIZE(SIZE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value-level model of the saturating add: integer sum clamped to the
    // magnitude range; only a zero result needs the sign rule.
    function automatic logic [SIZE-1:0] sm_add(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        int vx;
        int vy;
        int s;
        vx = x[SIZE-1] ? -int'(x[SIZE-2:0]) : int'(x[SIZE-2:0]);
        vy = y[SIZE-1] ? -int'(y[SIZE-2:0]) : int'(y[SIZE-2:0]);
        s  = vx + vy;
        if (s > MAXM) s = MAXM;
        if (s < -MAXM) s = -MAXM;
        if (s == 0) return {((x[SIZE-1] == y[SIZE-1]) ? x[SIZE-1] : y[SIZE-1]), 19'd0};
        if (s < 0) return {1'b1, 19'(-s)};
        return {1'b0, 19'(s)};
    endfunction

    function automatic logic [SIZE-1:0] neg(input logic [SIZE-1:0] x);
        return {~x[SIZE-1], x[SIZE-2:0]};
    endfunction

    // Model state: collected group, expected extrinsics, phase and position.
    logic [SIZE-1:0] m_vals [DEPTH];
    logic [SIZE-1:0] m_exp  [DEPTH];
    logic [SIZE-1:0] m_total = '0;
    logic            m_emit = 1'b0;
    int              m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_emit = 1'b0;
            m_cnt  = 0;
        end else if (flush) begin
            m_emit = 1'b0;
            m_cnt  = 0;
        end else if (!m_emit) begin
            if (in_valid) begin
                m_vals[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_total = '0;
                    for (int i = 0; i < DEPTH; i++) m_total = sm_add(m_total, m_vals[i]);
                    for (int i = 0; i < DEPTH; i++) m_exp[i] = sm_add(m_total, neg(m_vals[i]));
                    m_emit = 1'b1;
                    m_cnt  = 0;
                end
            end
        end else if (out_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_emit = 1'b0;
                m_cnt  = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_in_ready", 32'(in_ready), 32'(!m_emit && !flush));
        chk("cmp_out_valid", 32'(out_valid), 32'(m_emit));
        if (m_emit) begin
            chk("cmp_out_idx", 32'(out_idx), 32'(m_cnt));
            chk("cmp_out_data", 32'(out_data), 32'(m_exp[m_cnt]));
        end else begin
            chk("cmp_out_idx_idle", 32'(out_idx), 32'd0);
            chk("cmp_out_data_idle", 32'(out_data), 32'd0);
        end
    end

    // Callers enter every task at posedge + 2.
    task automatic put_one(input logic [SIZE-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic put_group(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                             input logic [SIZE-1:0] c, input logic [SIZE-1:0] d);
        put_one(a);
        put_one(b);
        put_one(c);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        chk("lat_before_last", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_after_last", 32'(out_valid), 32'd1);
        chk("in_ready_emit", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic drain(input logic [SIZE-1:0] e0, input logic [SIZE-1:0] e1,
                         input logic [SIZE-1:0] e2, input logic [SIZE-1:0] e3);
        logic [SIZE-1:0] e [DEPTH];
        e = '{e0, e1, e2, e3};
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk("drain_idx", 32'(out_idx), 32'(k));
            chk("drain_data", 32'(out_data), 32'(e[k]));
            @(posedge clk); #2;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Arithmetic: +5 -3 +10 -1
        put_group(20'h00005, 20'h80003, 20'h0000A, 20'h80001);
        chk("model_total_arith", 32'(m_total), 32'h0000B);
        drain(20'h00006, 20'h0000E, 20'h00001, 20'h0000C);
        $display("txn arith done");

        // Saturation, followed by backpressure in EMIT
        put_group(20'h61A80, 20'h61A80, 20'h00000, 20'h00000);
        chk("model_total_sat", 32'(m_total), 32'h7FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_idx", 32'(out_idx), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'(20'd124287));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #2;
        end
        drain(20'd124287, 20'd124287, 20'h7FFFF, 20'h7FFFF);
        $display("txn saturation/backpressure done");

        // Equal-magnitude cancel: +7 -7 +0 +0
        put_group(20'h00007, 20'h80007, 20'h00000, 20'h00000);
        chk("model_total_cancel", 32'(m_total), 32'h00000);
        drain(20'h80007, 20'h00007, 20'h80000, 20'h80000);
        $display("txn cancel done");

        // Flush in ACCUM after two inputs; the flush-cycle input is refused
        put_one(20'd100);
        put_one(20'd200);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 20'd999;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        flush    = 1'b0;
        in_valid = 1'b0;
        put_group(20'd1, 20'd2, 20'd3, 20'd4);
        chk("model_total_flush", 32'(m_total), 32'd10);
        drain(20'd9, 20'd8, 20'd7, 20'd6);
        $display("txn flush-accum done");

        // Flush during EMIT at idx1 handshake
        put_group(20'd2, 20'd4, 20'd6, 20'd8);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fe_idx0_data", 32'(out_data), 32'd18);
        @(posedge clk); #2;
        flush = 1'b1;
        @(negedge clk);
        chk("fe_idx1", 32'(out_idx), 32'd1);
        chk("fe_idx1_data", 32'(out_data), 32'd16);
        @(posedge clk); #2;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("fe_in_ready", 32'(in_ready), 32'd1);
        chk("fe_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        $display("txn flush-emit done");

        // Async reset mid-EMIT, between clock edges
        put_group(20'd3, 20'd3, 20'd3, 20'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        put_group(20'd1, 20'd1, 20'd1, 20'd1);
        chk("model_total_rst", 32'(m_total), 32'd4);
        drain(20'd3, 20'd3, 20'd3, 20'd3);
        $display("txn async-reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
